// File: rtl/count60_min.sv
// count60_min: minutes stage -- 1 s prescaler, seconds count, BCD minutes and carry pulse to hours.
// Define SEC_DISPLAY_EN to add BCD seconds outputs display_s0/display_s1 (SEC_PER_MIN=60 only).
module count60_min #(
   parameter int CLK_DIV     = 100000000,
   parameter int SEC_PER_MIN = 60
) (
   input  logic       ck,
   input  logic       rstn,
   input  logic       run,
   input  logic       inc_min,
   input  logic       clr_sec,
`ifdef SEC_DISPLAY_EN
   output logic [3:0] display_s0,
   output logic [3:0] display_s1,
`endif
   output logic [3:0] display1,
   output logic [3:0] display2,
   output logic       up24
);
   localparam int DW = $clog2(CLK_DIV);
   localparam int SW = $clog2(SEC_PER_MIN);
   logic [DW-1:0] div_cnt;
   logic [SW-1:0] sec_cnt;
   logic          sec_tick, sec_last, min_tick, min_ev, wrap;
   assign sec_tick = run && div_cnt == DW'(CLK_DIV - 1);
   assign sec_last = sec_cnt == SW'(SEC_PER_MIN - 1);
   // clear wins over a coincident final tick, so no minute carry is produced
   assign min_tick = sec_tick && sec_last && !clr_sec;
   assign min_ev   = min_tick || inc_min;
   assign wrap     = display2 == 4'd5 && display1 == 4'd9;
   always_ff @(posedge ck) begin
      if (!rstn) begin
         div_cnt  <= '0;
         sec_cnt  <= '0;
         display1 <= '0;
         display2 <= '0;
         up24     <= 1'b0;
`ifdef SEC_DISPLAY_EN
         display_s0 <= '0;
         display_s1 <= '0;
`endif
      end else begin
         if (clr_sec) begin
            div_cnt <= '0;
            sec_cnt <= '0;
`ifdef SEC_DISPLAY_EN
            display_s0 <= '0;
            display_s1 <= '0;
`endif
         end else if (sec_tick) begin
            div_cnt <= '0;
            sec_cnt <= sec_last ? '0 : sec_cnt + 1'b1;
`ifdef SEC_DISPLAY_EN
            display_s0 <= display_s0 == 4'd9 ? 4'd0 : display_s0 + 4'd1;
            display_s1 <= (display_s1 == 4'd5 && display_s0 == 4'd9) ? 4'd0 :
                          display_s0 == 4'd9 ? display_s1 + 4'd1 : display_s1;
`endif
         end else if (run) begin
            div_cnt <= div_cnt + 1'b1;
         end
         if (min_ev) begin
            display1 <= display1 == 4'd9 ? 4'd0 : display1 + 4'd1;
            display2 <= wrap ? 4'd0 : display1 == 4'd9 ? display2 + 4'd1 : display2;
         end
         up24 <= min_tick && wrap;
      end
   end
endmodule

// File: tb/tb_count60_min.sv
// tb_count60_min: directed bench for count60_min with CLK_DIV=4, SEC_PER_MIN=3 (one minute = 12 cycles).
module tb_count60_min;
   logic ck = 1'b0, rstn = 1'b0, run = 1'b1, inc_min = 1'b1, clr_sec = 1'b0;
   logic [3:0] display1, display2;
   logic up24;
   int checks = 0, errors = 0;
`ifdef SEC_DISPLAY_EN
   logic [3:0] display_s0, display_s1;
`endif
   count60_min #(.CLK_DIV(4), .SEC_PER_MIN(3)) dut (
      .ck(ck), .rstn(rstn), .run(run), .inc_min(inc_min), .clr_sec(clr_sec),
`ifdef SEC_DISPLAY_EN
      .display_s0(display_s0), .display_s1(display_s1),
`endif
      .display1(display1), .display2(display2), .up24(up24));
   always #5 ck = ~ck;
   task automatic tick(input int n);
      repeat (n) begin @(posedge ck); #1; end
   endtask
   task automatic set_min(input int n);
      rstn = 1'b0; run = 1'b0; inc_min = 1'b0; clr_sec = 1'b0;
      tick(1);
      rstn = 1'b1;
      repeat (n) begin inc_min = 1'b1; tick(1); end
      inc_min = 1'b0;
   endtask
   task automatic align_run;
      clr_sec = 1'b1; run = 1'b1;
      tick(1);
      clr_sec = 1'b0;
   endtask
   task automatic test_reset;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         checks++;
         if ({display2, display1, up24} !== 9'h000) begin errors++; $display("FAIL reset cyc%0d: got %h%h up24=%b, want 00 up24=0", i, display2, display1, up24); end
      end
      rstn = 1'b1; inc_min = 1'b0;
      tick(1);
      checks++;
      if (dut.div_cnt !== 2'd1 || dut.sec_cnt !== 2'd0) begin errors++; $display("FAIL reset_release: div=%0d sec=%0d, want div=1 sec=0", dut.div_cnt, dut.sec_cnt); end
      tick(2);
      rstn = 1'b0;
      tick(1);
      rstn = 1'b1;
      checks++;
      if (dut.div_cnt !== 2'd0 || dut.sec_cnt !== 2'd0) begin errors++; $display("FAIL reset_midcount: div=%0d sec=%0d, want 0 0", dut.div_cnt, dut.sec_cnt); end
   endtask
   task automatic test_auto_wrap;
      set_min(59);
      checks++;
      if ({display2, display1} !== 8'h59) begin errors++; $display("FAIL preload59: got %h%h, want 59", display2, display1); end
      align_run;
      tick(11);
      checks++;
      if ({display2, display1, up24} !== 9'b0101_1001_0) begin errors++; $display("FAIL auto_pre: got %h%h up24=%b, want 59 up24=0", display2, display1, up24); end
      tick(1);
      checks++;
      if ({display2, display1, up24} !== 9'b0000_0000_1) begin errors++; $display("FAIL auto_wrap: got %h%h up24=%b, want 00 up24=1", display2, display1, up24); end
      for (int i = 0; i < 12; i++) begin
         tick(1);
         checks++;
         if (up24 !== 1'b0) begin errors++; $display("FAIL auto_after cyc%0d: up24=%b, want 0", i, up24); end
      end
      checks++;
      if ({display2, display1} !== 8'h01) begin errors++; $display("FAIL auto_next: got %h%h, want 01", display2, display1); end
   endtask
   task automatic test_run_hold;
      set_min(5);
      align_run;
      tick(2);
      run = 1'b0;
      for (int i = 0; i < 50; i++) begin
         tick(1);
         checks++;
         if ({display2, display1, up24} !== 9'b0000_0101_0 || dut.div_cnt !== 2'd2) begin errors++; $display("FAIL hold cyc%0d: got %h%h up24=%b div=%0d, want 05 up24=0 div=2", i, display2, display1, up24, dut.div_cnt); end
      end
      run = 1'b1;
      tick(1);
      checks++;
      if (dut.div_cnt !== 2'd3) begin errors++; $display("FAIL resume: div=%0d, want 3", dut.div_cnt); end
      tick(1);
      checks++;
      if (dut.div_cnt !== 2'd0 || dut.sec_cnt !== 2'd1) begin errors++; $display("FAIL resume_tick: div=%0d sec=%0d, want 0 1", dut.div_cnt, dut.sec_cnt); end
   endtask
   task automatic test_manual_wrap;
      set_min(59);
      inc_min = 1'b1;
      tick(1);
      inc_min = 1'b0;
      checks++;
      if ({display2, display1, up24} !== 9'b0000_0000_0) begin errors++; $display("FAIL manual_wrap: got %h%h up24=%b, want 00 up24=0", display2, display1, up24); end
      set_min(9);
      inc_min = 1'b1;
      tick(1);
      inc_min = 1'b0;
      checks++;
      if ({display2, display1} !== 8'h10) begin errors++; $display("FAIL manual_09: got %h%h, want 10", display2, display1); end
   endtask
   task automatic test_simultaneous;
      set_min(58);
      align_run;
      tick(11);
      inc_min = 1'b1;
      tick(1);
      inc_min = 1'b0;
      checks++;
      if ({display2, display1, up24} !== 9'b0101_1001_0) begin errors++; $display("FAIL simul58: got %h%h up24=%b, want 59 up24=0", display2, display1, up24); end
      tick(11);
      inc_min = 1'b1;
      tick(1);
      inc_min = 1'b0;
      checks++;
      if ({display2, display1, up24} !== 9'b0000_0000_1) begin errors++; $display("FAIL simul59: got %h%h up24=%b, want 00 up24=1", display2, display1, up24); end
      tick(1);
      checks++;
      if ({display2, display1, up24} !== 9'b0000_0000_0) begin errors++; $display("FAIL simul_after: got %h%h up24=%b, want 00 up24=0", display2, display1, up24); end
   endtask
   task automatic test_clear_race;
      set_min(59);
      align_run;
      tick(11);
      clr_sec = 1'b1;
      tick(1);
      clr_sec = 1'b0;
      checks++;
      if ({display2, display1, up24} !== 9'b0101_1001_0 || dut.div_cnt !== 2'd0 || dut.sec_cnt !== 2'd0) begin errors++; $display("FAIL clear_race: got %h%h up24=%b div=%0d sec=%0d, want 59 up24=0 div=0 sec=0", display2, display1, up24, dut.div_cnt, dut.sec_cnt); end
      tick(12);
      checks++;
      if ({display2, display1, up24} !== 9'b0000_0000_1) begin errors++; $display("FAIL clear_then_wrap: got %h%h up24=%b, want 00 up24=1", display2, display1, up24); end
   endtask
   task automatic test_back_to_back;
      set_min(0);
      repeat (19) begin inc_min = 1'b1; tick(1); end
      inc_min = 1'b0;
      checks++;
      if ({display2, display1, up24} !== 9'b0001_1001_0) begin errors++; $display("FAIL back_to_back: got %h%h up24=%b, want 19 up24=0", display2, display1, up24); end
   endtask
   initial begin
      test_reset;
      test_auto_wrap;
      test_run_hold;
      test_manual_wrap;
      test_simultaneous;
      test_clear_race;
      test_back_to_back;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/count60_min.md
Name: count60_min

Overview:
- Minutes stage of the auto-increment clock. Sits directly upstream of the hours counter (count24).
- Divides the system clock into 1 s ticks, counts seconds, and keeps minutes as two BCD digits (00..59) for display digits 1/2.
- On each automatic 59->00 minute wrap it emits a one-cycle up24 pulse, which the hours counter consumes as its increment enable.
- Also provides manual minute increment and seconds clear for time setting.

Parameters:
- CLK_DIV, 100000000: ck cycles per second tick; legal range >= 2.
- SEC_PER_MIN, 60: seconds per minute; legal range >= 2. Small values are used only in benches.

Ports:
- ck  input  1  system clock; all state updates on the rising edge.
- rstn  input  1  synchronous, active-low reset.
- run  input  1  1 = timekeeping advances; 0 = prescaler and seconds hold.
- inc_min  input  1  one-cycle manual minute increment request (debounced, single-pulse upstream).
- clr_sec  input  1  synchronous clear of prescaler and seconds count.
- display1  output  4  minutes units, BCD 0..9.
- display2  output  4  minutes tens, BCD 0..5.
- up24  output  1  one-cycle carry pulse to the hours stage.

Behaviour:
- Reset (rstn=0 at posedge ck): div_cnt=0, sec_cnt=0, display1=0, display2=0, up24=0. Reset overrides every other input. Reset mid-count discards partial seconds.
- Prescaler div_cnt, width $clog2(CLK_DIV):
  - Counts 0..CLK_DIV-1 while run=1 and holds while run=0.
  - sec_tick (internal, combinational) = run && div_cnt==CLK_DIV-1. div_cnt wraps to 0 on that edge.
- Seconds sec_cnt, width $clog2(SEC_PER_MIN):
  - On sec_tick it increments.
  - At SEC_PER_MIN-1 it wraps to 0 and asserts internal min_tick in that same cycle.
- clr_sec=1: div_cnt<=0 and sec_cnt<=0. It beats a coincident sec_tick, so no min_tick is generated. Minutes are unaffected.
- Minute event = min_tick OR inc_min. A simultaneous min_tick and inc_min counts as ONE increment, never two.
- Minute increment rules, in BCD:
  - display2=5, display1=9: both go to 0 (wrap).
  - Otherwise display1=9: display1<=0, display2<=display2+1.
  - Otherwise: display1<=display1+1.
  - Digits never leave BCD range.
- up24:
  - Registered. It is 1 for exactly the one cycle in which display2/display1 first read 0/0 after a wrap caused by an event that included min_tick.
  - A wrap caused by inc_min alone does not pulse up24, so manual minute setting never moves hours.
  - up24 is 0 on every other cycle, and 0 whenever run=0 (min_tick requires run).
- Latency:
  - sec_tick to minute digit update: same edge (minutes update on the edge where sec_cnt wraps).
  - up24 rises on that edge.
  - The hours stage samples up24 and increments one edge later.
- inc_min while run=0: the increment still applies, with no up24.

Optional Feature:
- Macro SEC_DISPLAY_EN.
- Defined: adds output ports display_s0 [3:0] and display_s1 [3:0] carrying seconds units/tens in BCD.
  - Maintained as a BCD pair in parallel with sec_cnt, with the same clear, reset and wrap.
  - Valid only for SEC_PER_MIN=60, with wrap at 59->00.
- Undefined: these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- Reset: hold rstn=0 for 3 cycles with run=1 and inc_min=1. Required: display2/display1=0/0, up24=0 throughout, and counting starts from 0 after release.
- Auto wrap (CLK_DIV=4, SEC_PER_MIN=3, run=1): preload to 59 via 59 inc_min pulses, then clr_sec. After 12 cycles the minutes read 00, up24=1 for exactly 1 cycle, and no second up24 for the next 12 cycles.
- Run hold: run=0 for 50 cycles mid-second, starting at 05. Required: digits stay 05, up24=0, and div_cnt resumes from its held value when run=1.
- Manual wrap: at 59, pulse inc_min once. Required: 00 with up24=0. From 09, inc_min gives 10.
- Simultaneous: inc_min on the same cycle as min_tick at 58. Required: 59 (single increment). At 59 the same coincidence gives 00 with up24=1.
- Clear race: clr_sec asserted on the cycle of the final sec_tick of a minute. Required: minutes unchanged, up24=0, and sec_cnt=0, div_cnt=0 next cycle.
